// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT = 32;

    // Wide mask; the divider slices the low N bits for its saturated quotient.
    localparam int N_MAX = 128;
    localparam logic [N_MAX-1:0] QUOT_ALL_ONES = '1;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Combinational; the incoming remainder is always below the divisor, so the result fits in N bits.
module seq_div_step
    import seq_div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0] rem,
    input  logic         nxt_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N:0] shifted;

    always_comb begin
        shifted  = {rem, nxt_bit};
        // A set top bit means the (N+1)-bit value already exceeds any N-bit divisor.
        q_bit    = shifted[N] || (shifted[N-1:0] >= divisor);
        rem_next = q_bit ? (shifted[N-1:0] - divisor) : shifted[N-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned 2N/N restoring divider with valid/ready handshakes on both sides.
// N+1 cycles for a normal divide, one cycle for divide-by-zero or quotient overflow.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [2*N-1:0] DIVIDEND,
    input  logic [N-1:0]   DIVISOR,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [N-1:0]   QUOTIENT,
    output logic [N-1:0]   REMAINDER,
    output logic           DIV_BY_ZERO,
    output logic           OVERFLOW
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0] Q_SAT = QUOT_ALL_ONES[N-1:0];

    state_t        state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  prem;
    logic [N-1:0]  shreg;
    logic [N-1:0]  dvsr;
    logic [N-1:0]  rem_next;
    logic          q_bit;
    logic [N-1:0]  q_next;

    seq_div_step #(.N(N)) u_step (
        .rem      (prem),
        .nxt_bit  (shreg[N-1]),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Dividend low bits leave at the top of shreg while quotient bits enter at the bottom.
    assign q_next = {shreg[N-2:0], q_bit};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            IN_READY    <= 1'b1;
            OUT_VALID   <= 1'b0;
            cnt         <= '0;
            prem        <= '0;
            shreg       <= '0;
            dvsr        <= '0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        IN_READY <= 1'b0;
                        dvsr     <= DIVISOR;
                        if (DIVISOR == '0) begin
                            state       <= DONE;
                            OUT_VALID   <= 1'b1;
                            QUOTIENT    <= Q_SAT;
                            REMAINDER   <= DIVIDEND[N-1:0];
                            DIV_BY_ZERO <= 1'b1;
                            OVERFLOW    <= 1'b0;
                        end else if (DIVIDEND[2*N-1:N] >= DIVISOR) begin
                            state       <= DONE;
                            OUT_VALID   <= 1'b1;
                            QUOTIENT    <= Q_SAT;
                            REMAINDER   <= '0;
                            DIV_BY_ZERO <= 1'b0;
                            OVERFLOW    <= 1'b1;
                        end else begin
                            state <= CALC;
                            prem  <= DIVIDEND[2*N-1:N];
                            shreg <= DIVIDEND[N-1:0];
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    prem  <= rem_next;
                    shreg <= q_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N-1)) begin
                        state       <= DONE;
                        OUT_VALID   <= 1'b1;
                        QUOTIENT    <= q_next;
                        REMAINDER   <= rem_next;
                        DIV_BY_ZERO <= 1'b0;
                        OVERFLOW    <= 1'b0;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        state     <= IDLE;
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    IN_READY  <= 1'b1;
                    OUT_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed and random checks of seq_div against hand-computed values and a 64-bit reference.
module tb_seq_div;

    localparam int N = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic          IN_READY;
    logic [63:0]   DIVIDEND;
    logic [31:0]   DIVISOR;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [31:0]   QUOTIENT;
    logic [31:0]   REMAINDER;
    logic          DIV_BY_ZERO;
    logic          OVERFLOW;

    int errors = 0;
    int checks = 0;

    logic [31:0] r_q, r_r;
    logic        r_dz, r_ov;
    int          r_lat;

    always #5 CLK = ~CLK;

    seq_div #(.N(N)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .DIVIDEND    (DIVIDEND),
        .DIVISOR     (DIVISOR),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .QUOTIENT    (QUOTIENT),
        .REMAINDER   (REMAINDER),
        .DIV_BY_ZERO (DIV_BY_ZERO),
        .OVERFLOW    (OVERFLOW)
    );

    // Presents one operand pair, scrambles the inputs after acceptance, and waits for OUT_VALID.
    // r_lat counts the accepting edge as edge 1; it stays at the bound if no result appears.
    task automatic run_op(input logic [63:0] dd, input logic [31:0] dv);
        int guard;
        @(negedge CLK);
        DIVIDEND = dd;
        DIVISOR  = dv;
        IN_VALID = 1'b1;
        guard = 0;
        while (!IN_READY && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        DIVIDEND = {$urandom, $urandom};
        DIVISOR  = $urandom;
        r_lat = 1;
        @(negedge CLK);
        while (!OUT_VALID && r_lat < 100) begin
            @(negedge CLK);
            r_lat++;
        end
        r_q  = QUOTIENT;
        r_r  = REMAINDER;
        r_dz = DIV_BY_ZERO;
        r_ov = OVERFLOW;
    endtask

    task automatic ack();
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({IN_READY, OUT_VALID} !== 2'b10) begin
            errors++;
            $display("FAIL reset_hs: got rdy/vld=%b expected 10", {IN_READY, OUT_VALID});
        end
        checks++;
        if ({QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW} !== 66'd0) begin
            errors++;
            $display("FAIL reset_out: got q=%h r=%h dz=%b ov=%b expected all 0",
                     QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW);
        end
    endtask

    task automatic test_basic();
        run_op(64'd100, 32'd7);
        checks++;
        if (r_lat !== 33) begin
            errors++;
            $display("FAIL basic_lat: got %0d expected 33", r_lat);
        end
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'd14, 32'd2, 2'b00}) begin
            errors++;
            $display("FAIL basic_res: got q=%0d r=%0d dz=%b ov=%b expected q=14 r=2 dz=0 ov=0",
                     r_q, r_r, r_dz, r_ov);
        end
        ack();
        checks++;
        if ({IN_READY, OUT_VALID} !== 2'b10) begin
            errors++;
            $display("FAIL basic_ack: got rdy/vld=%b expected 10", {IN_READY, OUT_VALID});
        end
    endtask

    task automatic test_max();
        run_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'hFFFF_FFFF, 32'd0, 2'b00} || r_lat !== 33) begin
            errors++;
            $display("FAIL max_res: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=ffffffff r=0 flags 00 lat=33",
                     r_q, r_r, r_dz, r_ov, r_lat);
        end
        ack();
        // Largest high half that still fits: 5*2^32-1 = 5*(2^32-1)+4
        run_op(64'h0000_0004_FFFF_FFFF, 32'd5);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'hFFFF_FFFF, 32'd4, 2'b00}) begin
            errors++;
            $display("FAIL edge_fit: got q=%h r=%h dz=%b ov=%b expected q=ffffffff r=4 flags 00",
                     r_q, r_r, r_dz, r_ov);
        end
        ack();
    endtask

    task automatic test_overflow();
        run_op(64'h0000_0001_0000_0000, 32'd1);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'hFFFF_FFFF, 32'd0, 2'b01} || r_lat !== 1) begin
            errors++;
            $display("FAIL ovf_res: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=ffffffff r=0 dz=0 ov=1 lat=1",
                     r_q, r_r, r_dz, r_ov, r_lat);
        end
        ack();
        run_op(64'h0000_0005_0000_0000, 32'd5);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'hFFFF_FFFF, 32'd0, 2'b01} || r_lat !== 1) begin
            errors++;
            $display("FAIL ovf_equal: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=ffffffff r=0 dz=0 ov=1 lat=1",
                     r_q, r_r, r_dz, r_ov, r_lat);
        end
        ack();
    endtask

    task automatic test_div_zero();
        run_op(64'h1234, 32'd0);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'hFFFF_FFFF, 32'h1234, 2'b10} || r_lat !== 1) begin
            errors++;
            $display("FAIL dz_res: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=ffffffff r=1234 dz=1 ov=0 lat=1",
                     r_q, r_r, r_dz, r_ov, r_lat);
        end
        ack();
    endtask

    task automatic test_stall();
        int bad;
        run_op(64'd1000, 32'd3);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'd333, 32'd1, 2'b00}) begin
            errors++;
            $display("FAIL stall_res: got q=%0d r=%0d dz=%b ov=%b expected q=333 r=1 flags 00",
                     r_q, r_r, r_dz, r_ov);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1;
            DIVIDEND = 64'd55;
            DIVISOR  = 32'd5;
            @(negedge CLK);
            if ({QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW} !== {r_q, r_r, r_dz, r_ov} ||
                IN_READY !== 1'b0 || OUT_VALID !== 1'b1)
                bad++;
        end
        IN_VALID = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad);
        end
        ack();
        checks++;
        if ({IN_READY, OUT_VALID} !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: got rdy/vld=%b expected 10", {IN_READY, OUT_VALID});
        end
    endtask

    task automatic test_back_to_back();
        run_op(64'h0000_FFFF_FFFF_FFFF, 32'h0001_0000);
        ack();
        run_op(64'd7, 32'd9);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'd0, 32'd7, 2'b00} || r_lat !== 33) begin
            errors++;
            $display("FAIL b2b_second: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=0 r=7 flags 00 lat=33",
                     r_q, r_r, r_dz, r_ov, r_lat);
        end
        ack();
        run_op(64'h0000_FFFF_FFFF_FFFF, 32'h0001_0000);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'hFFFF_FFFF, 32'h0000_FFFF, 2'b00}) begin
            errors++;
            $display("FAIL b2b_wide: got q=%h r=%h dz=%b ov=%b expected q=ffffffff r=ffff flags 00",
                     r_q, r_r, r_dz, r_ov);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge CLK);
        DIVIDEND = 64'h00AB_CDEF;
        DIVISOR  = 32'd13;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        repeat (15) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({IN_READY, OUT_VALID, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW} !== {2'b10, 66'd0}) begin
            errors++;
            $display("FAIL rst_mid: got rdy=%b vld=%b q=%h r=%h dz=%b ov=%b expected rdy=1 rest 0",
                     IN_READY, OUT_VALID, QUOTIENT, REMAINDER, DIV_BY_ZERO, OVERFLOW);
        end
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (OUT_VALID) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_abandon: got %0d valid cycles expected 0", seen);
        end
        run_op(64'd100, 32'd7);
        checks++;
        if ({r_q, r_r, r_dz, r_ov} !== {32'd14, 32'd2, 2'b00} || r_lat !== 33) begin
            errors++;
            $display("FAIL rst_after: got q=%0d r=%0d dz=%b ov=%b lat=%0d expected q=14 r=2 flags 00 lat=33",
                     r_q, r_r, r_dz, r_ov, r_lat);
        end
        ack();
    endtask

    task automatic test_random();
        logic [31:0] a, b, rr, eq, er;
        logic [63:0] dd;
        logic        edz, eov;
        int          elat;
        for (int i = 0; i < 24; i++) begin
            a  = $urandom;
            b  = (i < 4) ? 32'($urandom_range(1, 20)) : ($urandom | 32'd1);
            rr = $urandom % b;
            dd = 64'(a) * 64'(b) + 64'(rr);
            run_op(dd, b);
            checks++;
            if ({r_q, r_r, r_dz, r_ov} !== {a, rr, 2'b00} || r_lat !== 33) begin
                errors++;
                $display("FAIL rand_prod %0d: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=%h flags 00 lat=33",
                         i, r_q, r_r, r_dz, r_ov, r_lat, a, rr);
            end
            ack();
        end
        for (int i = 0; i < 24; i++) begin
            dd = {$urandom >> (i % 32), $urandom};
            b  = (i % 6 == 0) ? 32'd0 : ($urandom >> (i % 32));
            if (b == 0) begin
                eq = '1; er = dd[31:0]; edz = 1'b1; eov = 1'b0; elat = 1;
            end else if (dd[63:32] >= b) begin
                eq = '1; er = '0; edz = 1'b0; eov = 1'b1; elat = 1;
            end else begin
                eq = 32'(dd / 64'(b)); er = 32'(dd % 64'(b)); edz = 1'b0; eov = 1'b0; elat = 33;
            end
            run_op(dd, b);
            checks++;
            if ({r_q, r_r, r_dz, r_ov} !== {eq, er, edz, eov} || r_lat !== elat) begin
                errors++;
                $display("FAIL rand_mix %0d: got q=%h r=%h dz=%b ov=%b lat=%0d expected q=%h r=%h dz=%b ov=%b lat=%0d",
                         i, r_q, r_r, r_dz, r_ov, r_lat, eq, er, edz, eov, elat);
            end
            ack();
        end
    endtask

    initial begin
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        DIVIDEND  = '0;
        DIVISOR   = '0;
        repeat (2) @(negedge CLK);
        test_reset();
        RST = 1'b0;
        test_basic();
        test_max();
        test_overflow();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
